stg_if: RTL and testbench
=========================

STG_IF -- requirements
Module: stg_if

Interface
REQ-001 Parameter RESET_PC, default `SIZE_ADDR'b0, first fetch address after reset.
REQ-002 iw_clk  in  1  sole clock, all state on rising edge.
REQ-003 iw_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 iw_stall  in  1  downstream stage is holding its latch; outputs SHALL not change.
REQ-005 iw_flush  in  1  redirect; discard in-flight work, resume at iw_branch_pc.
REQ-006 iw_branch_pc  in  `SIZE_ADDR  redirect target, sampled only when iw_flush=1.
REQ-007 ow_imem_req  out  1  instruction memory request valid.
REQ-008 ow_imem_addr  out  `SIZE_ADDR  request word address.
REQ-009 iw_imem_ack  in  1  memory response for current ow_imem_addr; legal only while ow_imem_req=1, may arrive in the request cycle.
REQ-010 iw_imem_data  in  `SIZE_DATA  instruction word, valid with iw_imem_ack.
REQ-011 ow_pc  out  `SIZE_ADDR  registered PC of ow_instr, feeds the next stage's iw_pc.
REQ-012 ow_instr  out  `SIZE_DATA  registered instruction, feeds the next stage's iw_instr.
REQ-013 ow_valid  out  1  ow_pc/ow_instr carry a real instruction, 0 = bubble.

Function
REQ-014 States: S_IDLE, S_REQ (fetch outstanding), S_DROP (outstanding fetch to discard), S_HOLD (response parked, downstream stalled).
REQ-015 Registers: fetch_pc (next address), req_addr (drives ow_imem_addr), hold_pc/hold_instr (one-entry skid buffer).
REQ-016 S_IDLE -> S_REQ after one clock; req_addr <= fetch_pc; no other action.
REQ-017 ow_imem_req SHALL be 1 in S_REQ and S_DROP, 0 in S_IDLE and S_HOLD; ow_imem_addr stable while req=1 and ack=0.
REQ-018 S_REQ, ack, !stall, !flush: ow_pc<=req_addr, ow_instr<=iw_imem_data, ow_valid<=1; fetch_pc/req_addr <= req_addr+1; stay S_REQ (1 instr/cycle with zero-wait memory).
REQ-019 S_REQ, ack, stall, !flush: hold_* <= req_addr/data; fetch_pc <= req_addr+1; outputs unchanged; -> S_HOLD.
REQ-020 S_REQ, !ack, !stall, !flush: bubble: ow_pc<=0, ow_instr<=0, ow_valid<=0.
REQ-021 Any state, stall, !flush, no capture: ow_pc/ow_instr/ow_valid hold.
REQ-022 S_HOLD, !stall, !flush: ow_* <= hold_*, ow_valid<=1; req_addr <= fetch_pc; -> S_REQ.
REQ-023 Flush SHALL take priority over stall and ack: ow_pc<=0, ow_instr<=0, ow_valid<=0; fetch_pc <= iw_branch_pc.
REQ-024 Flush in S_REQ without ack -> S_DROP (req_addr kept); with ack -> S_REQ, req_addr <= iw_branch_pc, data discarded.
REQ-025 Flush in S_HOLD: hold buffer discarded, req_addr <= iw_branch_pc, -> S_REQ; in S_IDLE: stay S_IDLE path with new fetch_pc.
REQ-026 S_DROP: on ack discard data, req_addr <= fetch_pc, -> S_REQ; flush in S_DROP updates fetch_pc only; outputs stay bubble.
REQ-027 Address increment SHALL be modulo 2^`SIZE_ADDR (all-ones + 1 wraps to 0).

Reset
REQ-028 iw_rst_n=0 SHALL immediately force: state S_IDLE, fetch_pc=req_addr=RESET_PC, ow_imem_req=0, ow_pc=0, ow_instr=0, ow_valid=0, hold_*=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the request; any ack while in reset is ignored.

Structure
REQ-030 Address/data widths SHALL come from `SIZE_ADDR/`HBIT_ADDR/`SIZE_DATA/`HBIT_DATA in sizes.vh; state encodings local parameters.
REQ-031 Single module; no sub-module (skid buffer is two registers).

Verification
REQ-032 Zero-wait memory, RESET_PC=0x10, no stall: ow_pc 0x10,0x11,0x12 on consecutive cycles after 2-cycle startup, ow_valid=1.
REQ-033 Ack at 0x20 with stall=1 for 3 cycles: req=0, outputs frozen; stall release -> ow_pc=0x20 next edge, then fetch 0x21.
REQ-034 Flush target 0x40 while 2-wait fetch of 0x05 outstanding: ow_valid=0, addr stays 0x05 until ack, then addr=0x40; 0x05 data never appears.
REQ-035 Flush and stall same cycle in S_HOLD: hold discarded, outputs zero, next request 0x40.
REQ-036 fetch at all-ones address: next ow_imem_addr=0.
REQ-037 iw_rst_n low mid-request: req=0 and outputs zero asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/stg_if_pkg.sv
// Shared definitions for the instruction-fetch stage: the address/data width
// macros, the fetch FSM state type and the wrapping PC increment helper.

`ifndef SIZES_VH
`define SIZES_VH
`define SIZE_ADDR 8
`define HBIT_ADDR 7
`define SIZE_DATA 32
`define HBIT_DATA 31
`endif

package stg_if_pkg;

    // Fetch controller states:
    // S_IDLE  waiting one clock before issuing the first request
    // S_REQ   a fetch to req_addr is outstanding
    // S_DROP  a fetch is outstanding but its response will be thrown away
    // S_HOLD  a response is parked in the skid buffer while downstream stalls
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // Next sequential word address; wraps from all-ones back to zero.
    function automatic logic [`HBIT_ADDR:0] next_addr(input logic [`HBIT_ADDR:0] addr);
        return addr + {{`HBIT_ADDR{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/stg_if.sv
// Instruction-fetch stage. Issues word requests to instruction memory, presents
// one registered instruction per cycle to the next stage, parks a response in a
// one-entry skid buffer when the next stage stalls, and redirects on flush while
// discarding any response that belongs to the old instruction stream.

module stg_if
    import stg_if_pkg::*;
#(
    parameter logic [`HBIT_ADDR:0] RESET_PC = '0
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  iw_stall,
    input  logic                  iw_flush,
    input  logic [`HBIT_ADDR:0]   iw_branch_pc,
    output logic                  ow_imem_req,
    output logic [`HBIT_ADDR:0]   ow_imem_addr,
    input  logic                  iw_imem_ack,
    input  logic [`HBIT_DATA:0]   iw_imem_data,
    output logic [`HBIT_ADDR:0]   ow_pc,
    output logic [`HBIT_DATA:0]   ow_instr,
    output logic                  ow_valid
);

    fetch_state_t          state;
    logic [`HBIT_ADDR:0]   fetch_pc;
    logic [`HBIT_ADDR:0]   req_addr;
    logic [`HBIT_ADDR:0]   hold_pc;
    logic [`HBIT_DATA:0]   hold_instr;

    // The request strobe is a pure decode of the state register, so it drops
    // the instant reset forces S_IDLE and never glitches on input changes.
    assign ow_imem_req  = (state == S_REQ) || (state == S_DROP);
    assign ow_imem_addr = req_addr;

    // Fetch FSM: sequences requests, captures responses into the output latch or
    // the skid buffer, and handles redirects with priority over stall and ack.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            ow_pc      <= '0;
            ow_instr   <= '0;
            ow_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iw_flush) begin
                        fetch_pc <= iw_branch_pc;
                        ow_pc    <= '0;
                        ow_instr <= '0;
                        ow_valid <= 1'b0;
                    end else begin
                        req_addr <= fetch_pc;
                        state    <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (iw_flush) begin
                        fetch_pc <= iw_branch_pc;
                        ow_pc    <= '0;
                        ow_instr <= '0;
                        ow_valid <= 1'b0;
                        if (iw_imem_ack) begin
                            req_addr <= iw_branch_pc;
                        end else begin
                            state <= S_DROP;
                        end
                    end else if (iw_imem_ack) begin
                        fetch_pc <= next_addr(req_addr);
                        if (iw_stall) begin
                            hold_pc    <= req_addr;
                            hold_instr <= iw_imem_data;
                            state      <= S_HOLD;
                        end else begin
                            ow_pc    <= req_addr;
                            ow_instr <= iw_imem_data;
                            ow_valid <= 1'b1;
                            req_addr <= next_addr(req_addr);
                        end
                    end else if (!iw_stall) begin
                        ow_pc    <= '0;
                        ow_instr <= '0;
                        ow_valid <= 1'b0;
                    end
                end

                S_DROP: begin
                    // A redirect that coincides with the stale response can jump
                    // straight to the new target; otherwise only fetch_pc moves.
                    if (iw_flush) begin
                        fetch_pc <= iw_branch_pc;
                        ow_pc    <= '0;
                        ow_instr <= '0;
                        ow_valid <= 1'b0;
                        if (iw_imem_ack) begin
                            req_addr <= iw_branch_pc;
                            state    <= S_REQ;
                        end
                    end else if (iw_imem_ack) begin
                        req_addr <= fetch_pc;
                        state    <= S_REQ;
                    end
                end

                S_HOLD: begin
                    if (iw_flush) begin
                        fetch_pc   <= iw_branch_pc;
                        req_addr   <= iw_branch_pc;
                        hold_pc    <= '0;
                        hold_instr <= '0;
                        ow_pc      <= '0;
                        ow_instr   <= '0;
                        ow_valid   <= 1'b0;
                        state      <= S_REQ;
                    end else if (!iw_stall) begin
                        ow_pc    <= hold_pc;
                        ow_instr <= hold_instr;
                        ow_valid <= 1'b1;
                        req_addr <= fetch_pc;
                        state    <= S_REQ;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stg_if.sv
// Directed testbench for the instruction-fetch stage. A small memory model
// answers requests after a programmable number of wait cycles; every expected
// value below is a hand-computed constant.

module tb_stg_if;

    logic                 clk;
    logic                 rst_n;
    logic                 stall;
    logic                 flush;
    logic [`HBIT_ADDR:0]  branchPc;
    logic                 imemReq;
    logic [`HBIT_ADDR:0]  imemAddr;
    logic                 imemAck;
    logic [`HBIT_DATA:0]  imemData;
    logic [`HBIT_ADDR:0]  outPc;
    logic [`HBIT_DATA:0]  outInstr;
    logic                 outValid;

    int                   waitCycles;
    logic                 memEnable;
    int                   waitCount;

    int                   checkCount;
    int                   errorCount;

    stg_if #(.RESET_PC(8'h10)) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_stall     (stall),
        .iw_flush     (flush),
        .iw_branch_pc (branchPc),
        .ow_imem_req  (imemReq),
        .ow_imem_addr (imemAddr),
        .iw_imem_ack  (imemAck),
        .iw_imem_data (imemData),
        .ow_pc        (outPc),
        .ow_instr     (outInstr),
        .ow_valid     (outValid)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory returns for a given address.
    function automatic logic [`HBIT_DATA:0] instrOf(input logic [`HBIT_ADDR:0] addr);
        return 32'hC0DE_0000 | {24'h0, addr};
    endfunction

    // Counts how long the current request has been waiting for its response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCount <= 0;
        end else if (!imemReq || imemAck) begin
            waitCount <= 0;
        end else begin
            waitCount <= waitCount + 1;
        end
    end

    // Memory responds once the programmed wait has elapsed.
    always_comb begin
        imemAck  = memEnable && imemReq && (waitCount >= waitCycles);
        imemData = imemAck ? instrOf(imemAddr) : 32'hDEAD_BEEF;
    end

    task automatic applyStimulus(input logic s, input logic f, input logic [`HBIT_ADDR:0] target);
        stall    = s;
        flush    = f;
        branchPc = target;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        waitCycles = 0;
        memEnable  = 1'b1;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset values
        step();
        checkOutput("rst_req",   {31'b0, imemReq}, 32'h0);
        checkOutput("rst_addr",  {24'b0, imemAddr}, 32'h10);
        checkOutput("rst_pc",    {24'b0, outPc}, 32'h0);
        checkOutput("rst_instr", outInstr, 32'h0);
        checkOutput("rst_valid", {31'b0, outValid}, 32'h0);
        rst_n = 1'b1;

        // Zero-wait streaming from RESET_PC
        step();
        checkOutput("start_req",   {31'b0, imemReq}, 32'h1);
        checkOutput("start_addr",  {24'b0, imemAddr}, 32'h10);
        checkOutput("start_valid", {31'b0, outValid}, 32'h0);
        step();
        checkOutput("stream0_pc",    {24'b0, outPc}, 32'h10);
        checkOutput("stream0_instr", outInstr, 32'hC0DE_0010);
        checkOutput("stream0_valid", {31'b0, outValid}, 32'h1);
        step();
        checkOutput("stream1_pc", {24'b0, outPc}, 32'h11);
        step();
        checkOutput("stream2_pc", {24'b0, outPc}, 32'h12);
        checkOutput("stream2_addr", {24'b0, imemAddr}, 32'h13);

        // Redirect to 0x1F with a response present, then stall on the 0x20 response
        applyStimulus(1'b0, 1'b1, 8'h1F);
        step();
        checkOutput("flushack_valid", {31'b0, outValid}, 32'h0);
        checkOutput("flushack_addr",  {24'b0, imemAddr}, 32'h1F);
        applyStimulus(1'b0, 1'b0, 8'h00);
        step();
        checkOutput("pre_stall_pc", {24'b0, outPc}, 32'h1F);
        checkOutput("pre_stall_addr", {24'b0, imemAddr}, 32'h20);
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_req",   {31'b0, imemReq}, 32'h0);
            checkOutput("stall_pc",    {24'b0, outPc}, 32'h1F);
            checkOutput("stall_valid", {31'b0, outValid}, 32'h1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        step();
        checkOutput("unstall_pc",    {24'b0, outPc}, 32'h20);
        checkOutput("unstall_instr", outInstr, 32'hC0DE_0020);
        checkOutput("unstall_addr",  {24'b0, imemAddr}, 32'h21);
        checkOutput("unstall_req",   {31'b0, imemReq}, 32'h1);
        step();
        checkOutput("after_unstall_pc", {24'b0, outPc}, 32'h21);

        // No response: stall holds outputs, no stall inserts a bubble
        memEnable = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        step();
        checkOutput("noack_stall_pc",    {24'b0, outPc}, 32'h21);
        checkOutput("noack_stall_valid", {31'b0, outValid}, 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        step();
        checkOutput("bubble_valid", {31'b0, outValid}, 32'h0);
        checkOutput("bubble_pc",    {24'b0, outPc}, 32'h0);
        checkOutput("bubble_addr",  {24'b0, imemAddr}, 32'h22);
        memEnable = 1'b1;

        // Flush while a 2-wait fetch of 0x05 is outstanding
        applyStimulus(1'b0, 1'b1, 8'h05);
        step();
        checkOutput("to05_addr", {24'b0, imemAddr}, 32'h05);
        waitCycles = 2;
        applyStimulus(1'b0, 1'b1, 8'h40);
        step();
        checkOutput("drop_addr",  {24'b0, imemAddr}, 32'h05);
        checkOutput("drop_req",   {31'b0, imemReq}, 32'h1);
        checkOutput("drop_valid", {31'b0, outValid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        step();
        checkOutput("drop_wait_addr", {24'b0, imemAddr}, 32'h05);
        step();
        checkOutput("redirect_addr",  {24'b0, imemAddr}, 32'h40);
        checkOutput("redirect_valid", {31'b0, outValid}, 32'h0);
        step();
        checkOutput("wait40_valid", {31'b0, outValid}, 32'h0);
        step();
        checkOutput("wait40b_valid", {31'b0, outValid}, 32'h0);
        step();
        checkOutput("fetch40_pc",    {24'b0, outPc}, 32'h40);
        checkOutput("fetch40_instr", outInstr, 32'hC0DE_0040);
        waitCycles = 0;

        // Flush and stall together while a response is parked
        applyStimulus(1'b1, 1'b0, 8'h00);
        step();
        checkOutput("park_req", {31'b0, imemReq}, 32'h0);
        checkOutput("park_pc",  {24'b0, outPc}, 32'h40);
        applyStimulus(1'b1, 1'b1, 8'h60);
        step();
        checkOutput("holdflush_valid", {31'b0, outValid}, 32'h0);
        checkOutput("holdflush_pc",    {24'b0, outPc}, 32'h0);
        checkOutput("holdflush_instr", outInstr, 32'h0);
        checkOutput("holdflush_addr",  {24'b0, imemAddr}, 32'h60);
        checkOutput("holdflush_req",   {31'b0, imemReq}, 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        step();
        checkOutput("fetch60_pc", {24'b0, outPc}, 32'h60);

        // Address wrap at all-ones
        applyStimulus(1'b0, 1'b1, 8'hFE);
        step();
        applyStimulus(1'b0, 1'b0, 8'h00);
        step();
        checkOutput("wrap_fe_pc", {24'b0, outPc}, 32'hFE);
        step();
        checkOutput("wrap_ff_pc",   {24'b0, outPc}, 32'hFF);
        checkOutput("wrap_addr",    {24'b0, imemAddr}, 32'h00);
        step();
        checkOutput("wrap_00_pc",    {24'b0, outPc}, 32'h00);
        checkOutput("wrap_00_instr", outInstr, 32'hC0DE_0000);
        checkOutput("wrap_00_valid", {31'b0, outValid}, 32'h1);

        // Asynchronous reset in the middle of a request
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_req",   {31'b0, imemReq}, 32'h0);
        checkOutput("async_valid", {31'b0, outValid}, 32'h0);
        checkOutput("async_instr", outInstr, 32'h0);
        checkOutput("async_addr",  {24'b0, imemAddr}, 32'h10);
        step();
        step();
        checkOutput("inreset_req", {31'b0, imemReq}, 32'h0);
        rst_n = 1'b1;
        step();
        checkOutput("restart_addr", {24'b0, imemAddr}, 32'h10);
        step();
        checkOutput("restart_pc",    {24'b0, outPc}, 32'h10);
        checkOutput("restart_valid", {31'b0, outValid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
